// File: rtl/cc_row_scroller_pkg.sv
// cc_row_scroller_pkg: state encodings, LFSR taps, score width and default seed for the row scroller.
package cc_row_scroller_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} scrollState_t;
    localparam int SCORE_W = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1 on bits 7,5,4,3
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/cc_row_lfsr.sv
// cc_row_lfsr: 8-bit Fibonacci LFSR with load/step enables; pattern always leaves one free lane.
module cc_row_lfsr
    import cc_row_scroller_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       load,
    input  logic       step,
    output logic [7:0] pattern
);
    logic [7:0] q;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) q <= SEED;
        else if (load) q <= SEED;
        else if (step) q <= lfsrNext(q);
    end
    assign pattern = (q == 8'hFF) ? (q & ~(8'b1 << q[2:0])) : q;
endmodule

// File: rtl/cc_row_scroller.sv
// cc_row_scroller: scrolling obstacle board with LFSR rows, prescaled ticks, score and IDLE/RUN/HALT control.
// Define CC_ROWSCROLLER_SPEEDUP_EN to let score[7:4] add to the speed select.
module cc_row_scroller
    import cc_row_scroller_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ROWS = 8,
    parameter int TICK_DIV = 25000000,
    parameter logic [7:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic                      CC_ROWSCROLLER_CLOCK_50,
    input  logic                      CC_ROWSCROLLER_RESET_InLow,
    input  logic                      CC_ROWSCROLLER_start_In,
    input  logic                      CC_ROWSCROLLER_pause_In,
    input  logic                      CC_ROWSCROLLER_collision_In,
    input  logic [1:0]                CC_ROWSCROLLER_speed_In,
    output logic [DATAWIDTH-1:0]      CC_ROWSCROLLER_fila0_Out,
    output logic [ROWS*DATAWIDTH-1:0] CC_ROWSCROLLER_board_Out,
    output logic                      CC_ROWSCROLLER_rowvalid_Out,
    output logic [SCORE_W-1:0]        CC_ROWSCROLLER_score_Out,
    output logic [1:0]                CC_ROWSCROLLER_state_Out
);
    localparam int PW = $clog2(TICK_DIV);
    scrollState_t state, stateNext;
    logic [PW-1:0] presc, lastCount;
    logic [DATAWIDTH-1:0] rows [ROWS];
    logic [7:0] pattern;
    logic [SCORE_W-1:0] score;
    logic [1:0] effSpeed;
    logic gapFlag, rowValid, tick, clear;

`ifdef CC_ROWSCROLLER_SPEEDUP_EN
    logic [4:0] speedSum;
    assign speedSum = {3'b000, CC_ROWSCROLLER_speed_In} + {1'b0, score[7:4]};
    assign effSpeed = (speedSum > 5'd3) ? 2'd3 : speedSum[1:0];
`else
    assign effSpeed = CC_ROWSCROLLER_speed_In;
`endif
    assign lastCount = PW'((TICK_DIV >> effSpeed) - 1);

    always_comb begin
        stateNext = state;
        clear = 1'b0;
        tick = 1'b0;
        case (state)
            RUN: begin
                stateNext = CC_ROWSCROLLER_collision_In ? HALT : RUN;
                tick = !CC_ROWSCROLLER_collision_In && !CC_ROWSCROLLER_pause_In && (presc >= lastCount);
            end
            default: begin
                stateNext = CC_ROWSCROLLER_start_In ? RUN : state;
                clear = CC_ROWSCROLLER_start_In;
            end
        endcase
    end

    always_ff @(posedge CC_ROWSCROLLER_CLOCK_50 or negedge CC_ROWSCROLLER_RESET_InLow) begin
        if (!CC_ROWSCROLLER_RESET_InLow) begin
            state <= IDLE;
            presc <= '0;
            gapFlag <= 1'b0;
            score <= '0;
            rowValid <= 1'b0;
        end else begin
            state <= stateNext;
            rowValid <= tick;
            if (clear) begin
                presc <= '0;
                gapFlag <= 1'b0;
                score <= '0;
            end else if (state == RUN && !CC_ROWSCROLLER_collision_In && !CC_ROWSCROLLER_pause_In) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) gapFlag <= ~gapFlag;
                if (tick && |rows[0] && score != '1) score <= score + 1'b1;
            end
        end
    end

    // gapFlag low means the next inserted row is a gap, so the first row after start is empty
    always_ff @(posedge CC_ROWSCROLLER_CLOCK_50 or negedge CC_ROWSCROLLER_RESET_InLow) begin
        if (!CC_ROWSCROLLER_RESET_InLow) rows <= '{default: '0};
        else if (clear) rows <= '{default: '0};
        else if (tick) begin
            for (int r = 0; r < ROWS - 1; r++) rows[r] <= rows[r+1];
            rows[ROWS-1] <= gapFlag ? DATAWIDTH'(pattern) : '0;
        end
    end

    cc_row_lfsr #(.SEED(LFSR_SEED)) uLfsr (
        .clk(CC_ROWSCROLLER_CLOCK_50),
        .rstN(CC_ROWSCROLLER_RESET_InLow),
        .load(clear),
        .step(tick),
        .pattern(pattern)
    );

    for (genvar g = 0; g < ROWS; g++) begin : gBoard
        assign CC_ROWSCROLLER_board_Out[g*DATAWIDTH +: DATAWIDTH] = rows[g];
    end
    assign CC_ROWSCROLLER_fila0_Out = rows[0];
    assign CC_ROWSCROLLER_rowvalid_Out = rowValid;
    assign CC_ROWSCROLLER_score_Out = score;
    assign CC_ROWSCROLLER_state_Out = state;
endmodule

// File: tb/tb_cc_row_scroller.sv
// tb_cc_row_scroller: randomized and directed checks of cc_row_scroller against a queue-based board model.
module tb_cc_row_scroller;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int TD = 8;
`ifdef CC_ROWSCROLLER_SPEEDUP_EN
    localparam int SAT_PERIOD = 1;
`else
    localparam int SAT_PERIOD = 8;
`endif

    logic clk = 1'b0, rstN = 1'b0, start = 1'b0, pause = 1'b0, collision = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [DW-1:0] fila0;
    logic [NR*DW-1:0] board;
    logic rowValid;
    logic [7:0] score;
    logic [1:0] stateOut;

    always #5 clk = ~clk;

    cc_row_scroller #(.DATAWIDTH(DW), .ROWS(NR), .TICK_DIV(TD), .LFSR_SEED(8'hA5)) dut (
        .CC_ROWSCROLLER_CLOCK_50(clk),
        .CC_ROWSCROLLER_RESET_InLow(rstN),
        .CC_ROWSCROLLER_start_In(start),
        .CC_ROWSCROLLER_pause_In(pause),
        .CC_ROWSCROLLER_collision_In(collision),
        .CC_ROWSCROLLER_speed_In(speed),
        .CC_ROWSCROLLER_fila0_Out(fila0),
        .CC_ROWSCROLLER_board_Out(board),
        .CC_ROWSCROLLER_rowvalid_Out(rowValid),
        .CC_ROWSCROLLER_score_Out(score),
        .CC_ROWSCROLLER_state_Out(stateOut)
    );

    int compared = 0;
    int mismatched = 0;

    // model: queue front is the bottom row, back is the top row
    logic [7:0] mRows[$];
    int mState, mScore, mPresc, mTicks;
    logic [7:0] mLfsr;
    bit mValid;

    function automatic logic [7:0] lfsrStep(input logic [7:0] x);
        int exps[4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (exps[i]) fb ^= x[exps[i]-1];
        return {x[6:0], fb};
    endfunction

    function automatic logic [7:0] freeLane(input logic [7:0] x);
        logic [7:0] m = 8'h01;
        return (x == 8'hFF) ? (x & ~(m << x[2:0])) : x;
    endfunction

    function automatic int speedNow();
        int s = int'(speed);
`ifdef CC_ROWSCROLLER_SPEEDUP_EN
        s = s + mScore / 16;
        if (s > 3) s = 3;
`endif
        return s;
    endfunction

    task automatic modelClear();
        mRows = {};
        for (int i = 0; i < NR; i++) mRows.push_back(8'h00);
        mScore = 0; mPresc = 0; mTicks = 0; mLfsr = 8'hA5; mValid = 0;
    endtask

    task automatic modelClock();
        int period;
        bit t = 0;
        logic [7:0] outRow;
        if (mState != 1) begin
            if (start) begin modelClear(); mState = 1; end
        end else if (collision) mState = 2;
        else if (!pause) begin
            period = TD >> speedNow();
            if (mPresc >= period - 1) begin mPresc = 0; t = 1; end
            else mPresc++;
        end
        if (t) begin
            outRow = mRows.pop_front();
            if (outRow != 0 && mScore < 255) mScore++;
            mRows.push_back((mTicks % 2 == 1) ? freeLane(mLfsr) : 8'h00);
            mTicks++;
            mLfsr = lfsrStep(mLfsr);
        end
        mValid = t;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        logic [NR*DW-1:0] b;
        for (int r = 0; r < NR; r++) b[r*DW +: DW] = mRows[r];
        check("state", 64'(stateOut), 64'(mState));
        check("fila0", 64'(fila0), 64'(mRows[0]));
        check("board", 64'(board), 64'(b));
        check("rowvalid", 64'(rowValid), 64'(mValid));
        check("score", 64'(score), 64'(mScore));
    endtask

    task automatic cycle();
        @(posedge clk);
        modelClock();
        @(negedge clk);
        compareAll();
    endtask

    task automatic waitValid(output int n);
        n = 0;
        do begin cycle(); n++; end while (!rowValid && n < 40);
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_state"}, 64'(stateOut), 64'd0);
        check({tag, "_fila0"}, 64'(fila0), 64'd0);
        check({tag, "_board"}, 64'(board), 64'd0);
        check({tag, "_rowvalid"}, 64'(rowValid), 64'd0);
        check({tag, "_score"}, 64'(score), 64'd0);
    endtask

    initial begin
        int n, cnt;
        mState = 0;
        modelClear();
        check("model_step_seed", 64'(lfsrStep(8'hA5)), 64'h4A);
        check("model_freelane_ff", 64'(freeLane(8'hFF)), 64'h7F);
        #2 checkZero("reset");
        @(negedge clk) rstN = 1'b1;
        repeat (3) cycle();
        // start, first ticks: gap row then the stepped seed
        start = 1'b1; cycle(); start = 1'b0;
        check("start_state", 64'(stateOut), 64'd1);
        waitValid(n);
        check("first_tick_delay", 64'(n), 64'd8);
        check("first_top_row", 64'(board[NR*DW-1 -: DW]), 64'h00);
        waitValid(n);
        check("second_tick_delay", 64'(n), 64'd8);
        check("second_top_row", 64'(board[NR*DW-1 -: DW]), 64'h4A);
        // speed 2: period 2
        speed = 2'd2; cnt = 0;
        repeat (20) begin cycle(); cnt += int'(rowValid); end
        check("speed2_ticks", 64'(cnt), 64'd10);
        // pause holds the prescaler mid-count
        cycle();
        pause = 1'b1; cnt = 0;
        repeat (10) begin cycle(); cnt += int'(rowValid); end
        check("pause_ticks", 64'(cnt), 64'd0);
        pause = 1'b0;
        waitValid(n);
        check("after_pause_delay", 64'(n), 64'd1);
        // collision on the tick cycle
        speed = 2'd0; cnt = 0;
        while (mPresc != TD - 1 && cnt < 20) begin cycle(); cnt++; end
        collision = 1'b1; cycle(); collision = 1'b0;
        check("coll_rowvalid", 64'(rowValid), 64'd0);
        check("coll_state", 64'(stateOut), 64'd2);
        repeat (4) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        check("restart_state", 64'(stateOut), 64'd1);
        check("restart_board", 64'(board), 64'd0);
        check("restart_score", 64'(score), 64'd0);
        // asynchronous reset mid-run with a populated board
        speed = 2'd3;
        repeat (20) cycle();
        check("board_populated", 64'(board != '0), 64'd1);
        #2 rstN = 1'b0;
        #1 checkZero("async_reset");
        mState = 0; modelClear();
        @(negedge clk) rstN = 1'b1;
        // saturation
        start = 1'b1; cycle(); start = 1'b0;
        repeat (700) cycle();
        check("score_saturated", 64'(score), 64'hFF);
        speed = 2'd0;
        waitValid(n);
        check("sat_period", 64'(n), 64'(SAT_PERIOD));
        // random traffic
        collision = 1'b1; cycle(); collision = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 9) == 0);
            collision = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) == 0);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
